// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Opcodes, flag bit positions and opcode decode helpers for the ALU.
//  Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    localparam int FLAG_V = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

    function automatic logic is_reserved(input logic [3:0] op);
        return op[3];
    endfunction

    // Which NZV bits a port-0 operation is allowed to overwrite.
    function automatic logic [2:0] flag_mask(input logic [3:0] op);
        logic [2:0] m;
        m = 3'b000;
        case (op)
            OP_ADD, OP_SUB:                 m = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'(1 << FLAG_Z);
            default:                        m = 3'b000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Brief    : Combinational 16-bit ALU with N/Z/V outputs.
//  Revision : 1.0
// ============================================================================
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_res,
    output logic        o_n,
    output logic        o_z,
    output logic        o_v
);

    logic [3:0]  w_sh;
    logic [15:0] w_sum;
    logic [15:0] w_diff;
    logic [15:0] w_sll;
    logic [15:0] w_sra;
    logic [15:0] w_ror;
    logic [15:0] w_paddsb;

    assign w_sh   = i_b[3:0];
    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_sll  = i_a << w_sh;
    assign w_sra  = $signed(i_a) >>> w_sh;
    assign w_ror  = (i_a >> w_sh) | (i_a << (5'd16 - {1'b0, w_sh}));

    // Saturating signed byte add: a 9-bit sign-extended sum exposes overflow.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [8:0] w_s;
            assign w_s = {i_a[8*gi+7], i_a[8*gi +: 8]} + {i_b[8*gi+7], i_b[8*gi +: 8]};
            assign w_paddsb[8*gi +: 8] = (w_s[8] != w_s[7]) ? (w_s[8] ? 8'h80 : 8'h7F)
                                                            : w_s[7:0];
        end
    endgenerate

    always_comb begin
        o_res = 16'h0000;
        o_v   = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_res = w_sum;
                o_v   = (i_a[15] == i_b[15]) && (w_sum[15] != i_a[15]);
            end
            OP_SUB: begin
                o_res = w_diff;
                o_v   = (i_a[15] != i_b[15]) && (w_diff[15] != i_a[15]);
            end
            OP_XOR:    o_res = i_a ^ i_b;
            OP_RED:    o_res = {15'b0, ^i_a};
            OP_SLL:    o_res = w_sll;
            OP_SRA:    o_res = w_sra;
            OP_ROR:    o_res = w_ror;
            OP_PADDSB: o_res = w_paddsb;
            default:   o_res = 16'h0000;
        endcase
    end

    assign o_n = o_res[15];
    assign o_z = (o_res == 16'h0000);

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Brief    : Two-port arbiter in front of the shared ALU; owns the NZV flags.
//  Revision : 1.0
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          req0,
    input  logic [3:0]    op0,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] b0,
    output logic          gnt0,
    output logic          rsp_valid0,
    output logic [DW-1:0] result0,
    input  logic          req1,
    input  logic [3:0]    op1,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    output logic          gnt1,
    output logic          rsp_valid1,
    output logic [DW-1:0] result1,
    output logic [2:0]    flags,
    output logic          err
);

    logic          r_last_gnt;
    logic          r_rsp_valid0;
    logic          r_rsp_valid1;
    logic [DW-1:0] r_result0;
    logic [DW-1:0] r_result1;
    logic [2:0]    r_flags;
    logic          r_err;

    logic          w_gnt0;
    logic          w_gnt1;
    logic [3:0]    w_op;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [DW-1:0] w_alu_res;
    logic [DW-1:0] w_load;
    logic          w_alu_n;
    logic          w_alu_z;
    logic          w_alu_v;
    logic [2:0]    w_alu_nzv;
    logic [2:0]    w_mask;

    // Port 0 wins unless port 1 also requests and round-robin says it is port 1's turn.
    assign w_gnt0 = en && req0 && (!req1 || !RR_EN || r_last_gnt);
    assign w_gnt1 = en && req1 && !w_gnt0;

    assign w_op = w_gnt1 ? op1 : op0;
    assign w_a  = w_gnt1 ? a1  : a0;
    assign w_b  = w_gnt1 ? b1  : b0;

    alu u_alu (
        .i_op  (w_op),
        .i_a   (w_a),
        .i_b   (w_b),
        .o_res (w_alu_res),
        .o_n   (w_alu_n),
        .o_z   (w_alu_z),
        .o_v   (w_alu_v)
    );

    assign w_load = is_reserved(w_op) ? '0 : w_alu_res;

    always_comb begin
        w_alu_nzv         = 3'b000;
        w_alu_nzv[FLAG_N] = w_alu_n;
        w_alu_nzv[FLAG_Z] = w_alu_z;
        w_alu_nzv[FLAG_V] = w_alu_v;
    end

    assign w_mask = w_gnt0 ? flag_mask(op0) : 3'b000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_gnt   <= 1'b1;
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_result0    <= '0;
            r_result1    <= '0;
            r_flags      <= 3'b000;
            r_err        <= 1'b0;
        end else begin
            r_rsp_valid0 <= w_gnt0;
            r_rsp_valid1 <= w_gnt1;
            r_err        <= (w_gnt0 || w_gnt1) && is_reserved(w_op);
            r_flags      <= (r_flags & ~w_mask) | (w_alu_nzv & w_mask);
            if (w_gnt0) begin
                r_result0  <= w_load;
                r_last_gnt <= 1'b0;
            end
            if (w_gnt1) begin
                r_result1  <= w_load;
                r_last_gnt <= 1'b1;
            end
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign rsp_valid0 = r_rsp_valid0;
    assign rsp_valid1 = r_rsp_valid1;
    assign result0    = r_result0;
    assign result1    = r_result1;
    assign flags      = r_flags;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Brief    : Directed and random checks of alu_arbiter against a reference model.
//  Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic        req0, req1;
    logic [3:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, rsp_valid0, rsp_valid1, err;
    logic [15:0] result0, result1;
    logic [2:0]  flags;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic        m_last;
    logic        m_rv0, m_rv1, m_err;
    logic [15:0] m_res0, m_res1;
    logic [2:0]  m_flags;
    logic        m_g0, m_g1;
    logic        obs_g0, obs_g1;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1'b1), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .gnt0(gnt0), .rsp_valid0(rsp_valid0), .result0(result0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt1(gnt1), .rsp_valid1(rsp_valid1), .result1(result1),
        .flags(flags), .err(err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {N, Z, V, result} from the arithmetic meaning of each opcode.
    function automatic logic [18:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        int sa, sb, s, sh, cnt, x;
        logic [15:0] r;
        logic v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[3:0]);
        r = 16'h0;
        v = 1'b0;
        case (op)
            4'd0: begin s = sa + sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            4'd1: begin s = sa - sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            4'd2: r = a ^ b;
            4'd3: begin
                cnt = 0;
                for (int i = 0; i < 16; i++) cnt += int'(a[i]);
                r = 16'(cnt % 2);
            end
            4'd4: r = 16'(a << sh);
            4'd5: begin s = sa >>> sh; r = s[15:0]; end
            4'd6: begin
                r = a;
                for (int i = 0; i < sh; i++) r = {r[0], r[15:1]};
            end
            4'd7: begin
                for (int i = 0; i < 2; i++) begin
                    x = int'($signed(a[8*i +: 8])) + int'($signed(b[8*i +: 8]));
                    if (x > 127) x = 127;
                    if (x < -128) x = -128;
                    r[8*i +: 8] = x[7:0];
                end
            end
            default: r = 16'h0;
        endcase
        return {r[15], (r == 16'h0), v, r};
    endfunction

    task automatic cyc(input logic e, input logic rn,
                       input logic r0, input logic [3:0] o0, input logic [15:0] x0, input logic [15:0] y0,
                       input logic r1, input logic [3:0] o1, input logic [15:0] x1, input logic [15:0] y1);
        logic [18:0] ra;
        logic [3:0]  op;
        @(negedge clk);
        en = e; rst_n = rn;
        req0 = r0; op0 = o0; a0 = x0; b0 = y0;
        req1 = r1; op1 = o1; a1 = x1; b1 = y1;
        #1;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (e) begin
            if (r0 && !r1) m_g0 = 1'b1;
            else if (r1 && !r0) m_g1 = 1'b1;
            else if (r0 && r1) begin
                if (m_last == 1'b0) m_g1 = 1'b1;
                else m_g0 = 1'b1;
            end
        end
        obs_g0 = gnt0;
        obs_g1 = gnt1;
        chk("gnt0", {15'b0, gnt0}, {15'b0, m_g0});
        chk("gnt1", {15'b0, gnt1}, {15'b0, m_g1});
        if (!rn) begin
            m_last = 1'b1; m_rv0 = 1'b0; m_rv1 = 1'b0; m_err = 1'b0;
            m_res0 = 16'h0; m_res1 = 16'h0; m_flags = 3'b000;
        end else begin
            m_rv0 = m_g0;
            m_rv1 = m_g1;
            m_err = 1'b0;
            if (m_g0 || m_g1) begin
                op = m_g0 ? o0 : o1;
                ra = m_g0 ? ref_alu(o0, x0, y0) : ref_alu(o1, x1, y1);
                m_err = op[3];
                if (m_g0) begin
                    m_res0 = op[3] ? 16'h0 : ra[15:0];
                    m_last = 1'b0;
                    if (op == 4'd0 || op == 4'd1) m_flags = ra[18:16];
                    else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6)
                        m_flags[1] = ra[17];
                end else begin
                    m_res1 = op[3] ? 16'h0 : ra[15:0];
                    m_last = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("rsp_valid0", {15'b0, rsp_valid0}, {15'b0, m_rv0});
        chk("rsp_valid1", {15'b0, rsp_valid1}, {15'b0, m_rv1});
        chk("result0", result0, m_res0);
        chk("result1", result1, m_res1);
        chk("flags", {13'b0, flags}, {13'b0, m_flags});
        chk("err", {15'b0, err}, {15'b0, m_err});
    endtask

    logic [3:0]  rr_seq;
    logic        p0, p1, e;
    logic [3:0]  ro0, ro1;
    logic [15:0] ra0, rb0, ra1, rb1;
    logic [15:0] k0, k1;

    initial begin
        rst_n = 1'b0; en = 1'b0;
        req0 = 1'b0; op0 = 4'h0; a0 = 16'h0; b0 = 16'h0;
        req1 = 1'b0; op1 = 4'h0; a1 = 16'h0; b1 = 16'h0;
        m_last = 1'b1; m_rv0 = 1'b0; m_rv1 = 1'b0; m_err = 1'b0;
        m_res0 = 16'h0; m_res1 = 16'h0; m_flags = 3'b000;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0);
        chk("reset_flags", {13'b0, flags}, 16'h0);

        // ADD overflow: 0x7FFF + 1 -> 0x8000, N=1 Z=0 V=1
        cyc(1'b1, 1'b1, 1'b1, 4'h0, 16'h7FFF, 16'h0001, 1'b0, 4'h0, 16'h0, 16'h0);
        chk("add_gnt", {15'b0, obs_g0}, 16'h1);
        chk("add_result", result0, 16'h8000);
        chk("add_flags", {13'b0, flags}, 16'h5);

        // RED with flags 101: parity of 0x0007 is 1, flags stay
        cyc(1'b1, 1'b1, 1'b1, 4'h3, 16'h0007, 16'h0000, 1'b0, 4'h0, 16'h0, 16'h0);
        chk("red_result", result0, 16'h0001);
        chk("red_flags", {13'b0, flags}, 16'h5);

        // Port 1 SUB giving zero leaves flags alone
        cyc(1'b1, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 4'h1, 16'h0005, 16'h0005);
        chk("p1_sub_result", result1, 16'h0000);
        chk("p1_sub_flags", {13'b0, flags}, 16'h5);

        // Both ports continuously for 4 cycles: grants 0,1,0,1
        k0 = 16'h0; k1 = 16'h0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 4'h0, 16'h0100 + k0, 16'h0011, 1'b1, 4'h2, 16'h0F0F, 16'h00F0 + k1);
            rr_seq[i] = obs_g0;
            if (obs_g0) k0++;
            if (obs_g1) k1++;
        end
        chk("rr_pattern", {12'b0, rr_seq}, 16'h0005);

        // After reset: port 1 SUB keeps flags 000, port 0 XOR sets only Z
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 4'h1, 16'h0005, 16'h0005);
        chk("sub_p1_flags", {13'b0, flags}, 16'h0);
        cyc(1'b1, 1'b1, 1'b1, 4'h2, 16'h00FF, 16'h00FF, 1'b0, 4'h0, 16'h0, 16'h0);
        chk("xor_flags", {13'b0, flags}, 16'h2);

        // Reserved opcode
        cyc(1'b1, 1'b1, 1'b1, 4'hA, 16'h1234, 16'h4321, 1'b0, 4'h0, 16'h0, 16'h0);
        chk("rsv_gnt", {15'b0, obs_g0}, 16'h1);
        chk("rsv_result", result0, 16'h0000);
        chk("rsv_err", {15'b0, err}, 16'h1);
        chk("rsv_flags", {13'b0, flags}, 16'h2);
        cyc(1'b1, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0);
        chk("rsv_err_pulse", {15'b0, err}, 16'h0);

        // Set some flags, then reset on the edge that would return a grant
        cyc(1'b1, 1'b1, 1'b1, 4'h1, 16'h0000, 16'h0001, 1'b0, 4'h0, 16'h0, 16'h0);
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 16'h0001, 16'h0001, 1'b0, 4'h0, 16'h0, 16'h0);
        chk("rst_rsp_valid0", {15'b0, rsp_valid0}, 16'h0);
        chk("rst_flags2", {13'b0, flags}, 16'h0);
        cyc(1'b1, 1'b1, 1'b1, 4'h0, 16'h0002, 16'h0003, 1'b1, 4'h0, 16'h0004, 16'h0005);
        chk("rst_tie_p0", {15'b0, obs_g0}, 16'h1);

        // en low with a pending request: no grant, flags hold, then granted
        cyc(1'b1, 1'b1, 1'b1, 4'h0, 16'h8000, 16'h0001, 1'b0, 4'h0, 16'h0, 16'h0);
        cyc(1'b0, 1'b1, 1'b1, 4'h0, 16'hFFFF, 16'h0001, 1'b0, 4'h0, 16'h0, 16'h0);
        chk("en0_gnt0", {15'b0, obs_g0}, 16'h0);
        chk("en0_flags", {13'b0, flags}, 16'h4);
        cyc(1'b0, 1'b1, 1'b1, 4'h0, 16'hFFFF, 16'h0001, 1'b0, 4'h0, 16'h0, 16'h0);
        cyc(1'b1, 1'b1, 1'b1, 4'h0, 16'hFFFF, 16'h0001, 1'b0, 4'h0, 16'h0, 16'h0);
        chk("en1_gnt0", {15'b0, obs_g0}, 16'h1);
        chk("en1_flags", {13'b0, flags}, 16'h2);

        // In-flight response completes while en is low
        cyc(1'b1, 1'b1, 1'b1, 4'h4, 16'h0001, 16'h0004, 1'b0, 4'h0, 16'h0, 16'h0);
        chk("inflight_result", result0, 16'h0010);
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0);

        // Random traffic; requesters hold operands until granted
        p0 = 1'b0; p1 = 1'b0;
        ro0 = 4'h0; ro1 = 4'h0; ra0 = 16'h0; rb0 = 16'h0; ra1 = 16'h0; rb1 = 16'h0;
        for (int n = 0; n < 400; n++) begin
            if (!p0 && ($urandom_range(0, 2) != 0)) begin
                p0 = 1'b1;
                ro0 = ($urandom_range(0, 8) == 8) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
                ra0 = 16'($urandom); rb0 = 16'($urandom);
            end
            if (!p1 && ($urandom_range(0, 2) != 0)) begin
                p1 = 1'b1;
                ro1 = ($urandom_range(0, 8) == 8) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
                ra1 = 16'($urandom); rb1 = 16'($urandom);
            end
            e = ($urandom_range(0, 7) != 0);
            cyc(e, 1'b1, p0, ro0, ra0, rb0, p1, ro1, ra1, rb1);
            if (m_g0) p0 = 1'b0;
            if (m_g1) p1 = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 16-bit ALU between two requesters. Port 0 is the pipeline execute stage; port 1 is the auxiliary address/branch-target unit. The block does round-robin (or fixed) arbitration, registers the winning result for one cycle, and owns the architectural NZV flag register, which only port 0 may update. It sits between the decode/execute pipeline registers and the combinational alu instance.

Parameters:
RR_EN, 1, 1 = round-robin on ties; 0 = port 0 always wins ties
DW, 16, datapath width; fixed at 16 because the alu is 16-bit only

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  global enable; when 0, no grants are issued and all state holds
req0  in  1  port 0 request; op0/a0/b0 held stable until gnt0
op0  in  4  port 0 ALU opcode
a0  in  16  port 0 operand A
b0  in  16  port 0 operand B
gnt0  out  1  combinational grant to port 0
rsp_valid0  out  1  port 0 result valid; pulses for one cycle
result0  out  16  port 0 registered result
req1, op1, a1, b1, gnt1, rsp_valid1, result1: same as port 0, for port 1
flags  out  3  registered flags, {N,Z,V} = flags[2:0] bit order [2]=N [1]=Z [0]=V
err  out  1  one-cycle pulse: a reserved opcode was granted

Behaviour:
- Reset (rst_n=0 at clk edge) clears the following: rsp_valid0/1=0, result0/1=0, flags=000, err=0, last_gnt=1 (so port 0 wins the first tie). Reset mid-transaction discards any pending response.
- Grant is combinational and one-hot or zero. It is zero when en=0. With one requester, that requester is granted. With both requesting: if RR_EN=1, grant the port ≠ last_gnt; if RR_EN=0, grant port 0.
- last_gnt updates on every grant cycle to the granted port index.
- The granted port's op/a/b drive the alu in that same cycle.
- At the next edge, the granted port's result register loads the alu result and its rsp_valid goes to 1 for exactly one cycle. Latency is 1 cycle from the grant cycle. There is no response backpressure.
- The ungranted port's result register holds its last value. Its rsp_valid is 0.
- Back-to-back grants are allowed every cycle. With continuous requests on both ports and RR_EN=1, grants alternate 0,1,0,1.
- Opcodes: 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB. The range 1xxx is reserved.
- Reserved opcode granted: the result loads 0, rsp_valid still pulses, flags are not updated, and err pulses 1 in the response cycle.
- Flag update happens only on a port 0 grant with en=1:
  - ADD/SUB: N, Z and V all load from the alu.
  - XOR/SLL/SRA/ROR: Z loads; N and V hold.
  - RED/PADDSB/reserved: no change.
- Port 1 grants never touch flags.
- Flags become visible one cycle after the grant, coincident with rsp_valid0.
- If en drops while a request is pending, the request stays pending (requester holds) and is granted when en returns. A response already in flight still completes on the following edge.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD … OP_PADDSB)
  - flag bit indices FLAG_V=0, FLAG_Z=1, FLAG_N=2
  - a function is_reserved(op)
  - a function flag_mask(op) returning the 3-bit update mask
- One sub-module: the existing alu instance. The arbitration logic, operand mux and flag register live in alu_arbiter itself.

Test Plan:
- Reset then req0 ADD a=0x7FFF b=0x0001: gnt0=1 in the same cycle. Next cycle rsp_valid0=1, result0 reflects the alu's overflow behaviour, and flags updated with V=1; no flag update on any port-1 grant.
- Both ports request continuously for 4 cycles with RR_EN=1: grants are 0,1,0,1. Each port sees rsp_valid every other cycle, and the results match the respective operands.
- Port 1 SUB a=5 b=5, then port 0 XOR a=0x00FF b=0x00FF:
  - after port 1, flags remain 000;
  - after port 0, Z=1 and N/V are unchanged.
- Port 0 RED after flags={1,0,1}: flags stay 101; result0 loads the alu RED output.
- Port 0 op=1010: gnt0=1. Next cycle result0=0, rsp_valid0=1, err=1 for one cycle, and flags unchanged.
- rst_n=0 asserted in the cycle after a grant: rsp_valid0 is 0 at that edge, flags=000, and the next tie goes to port 0. Separately, en=0 with req0 high: gnt0=0 and flags hold; gnt0 is asserted in the first cycle en=1.
